pipeline_stall_controller: RTL and testbench

Consumes the hazard requests raised in decode (load-use hazard, decoded branch/jal/jalr) and turns them into cycle-accurate pipeline control: PC write enable, IF/ID write/flush, ID/EX bubble insertion and PC redirect. It sits between decode-stage hazard detection and the IF/ID/EX pipeline registers. It holds fetch across unresolved control transfers until EX resolves them, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 32 +++
 rtl/pipeline_stall_controller.sv | 169 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control blocks.
//   ctrl_state_e : control FSM states (RUN, LOAD_STALL, CTRL_WAIT, REDIRECT)
//   RESET_PC     : value the redirect target takes out of reset
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_CTRL_WAIT  = 2'd2,
      ST_REDIRECT   = 2'd3
   } ctrl_state_e;

   localparam int unsigned RESET_PC = 0;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset, clears count
//   inc   in  add one this cycle (ignored once saturated)
//   clear in  synchronous clear, wins over inc
//   count out current value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Turns decode-stage hazard requests into IF/ID/EX pipeline control. Load-use
// hazards insert LOAD_BUBBLES bubbles; branch/jal/jalr hold fetch until EX
// resolves them, then either redirect the PC or resume fall-through fetch.
// A watchdog abandons a wait after MAX_WAIT cycles and flags ctrl_timeout.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   load_use_hazard  ID instruction depends on an in-flight load
//   ctrl_flow        ID instruction is a branch, jal or jalr
//   resolve_valid    EX resolved the outstanding control instruction (pulse)
//   resolve_taken    transfer taken (qualified by resolve_valid)
//   resolve_target   redirect PC (qualified by resolve_valid & resolve_taken)
//   pc_write         PC load enable
//   ifid_write       IF/ID load enable
//   ifid_flush       IF/ID loads a NOP
//   idex_bubble      ID/EX loads a NOP
//   pc_sel           PC mux selects pc_target
//   pc_target        registered redirect target
//   busy             controller not in RUN
//   ctrl_timeout     sticky: a control wait expired without a resolve
//   stall_cycles     saturating count of cycles with pc_write low
// -----------------------------------------------------------------------------
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int CNT_W        = 16,
   parameter int LOAD_BUBBLES = 1,
   parameter int MAX_WAIT     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_use_hazard,
   input  logic              ctrl_flow,
   input  logic              resolve_valid,
   input  logic              resolve_taken,
   input  logic [ADDR_W-1:0] resolve_target,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              pc_sel,
   output logic [ADDR_W-1:0] pc_target,
   output logic              busy,
   output logic              ctrl_timeout,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int BUB_W  = 3;   // holds up to LOAD_BUBBLES-1 = 6
   localparam int WAIT_W = 8;   // holds up to MAX_WAIT-1 = 254

   ctrl_state_e       state;
   logic [BUB_W-1:0]  bub_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   // Control outputs react in the same cycle a request appears, so they are
   // decoded from the state and the live RUN-state inputs. Holding rst_n in
   // the decode keeps every enable low while reset is asserted.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel      = 1'b0;
      busy        = 1'b0;
      if (rst_n) begin
         busy = (state != ST_RUN);
         unique case (state)
            ST_RUN: begin
               if (load_use_hazard) begin
                  idex_bubble = 1'b1;
               end else if (ctrl_flow) begin
                  // The control instruction moves on to EX; whatever fetch
                  // delivers behind it is squashed until it resolves.
                  ifid_flush = 1'b1;
                  ifid_write = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
               end
            end
            ST_LOAD_STALL: begin
               idex_bubble = 1'b1;
            end
            ST_CTRL_WAIT: begin
               ifid_flush = 1'b1;
               ifid_write = 1'b1;
            end
            ST_REDIRECT: begin
               pc_sel     = 1'b1;
               pc_write   = 1'b1;
               ifid_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         bub_cnt      <= '0;
         wait_cnt     <= '0;
         pc_target    <= ADDR_W'(RESET_PC);
         ctrl_timeout <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               // Load hazard takes priority; a held ctrl_flow is picked up on
               // the first RUN cycle after the bubbles drain.
               if (load_use_hazard) begin
                  if (LOAD_BUBBLES > 1) begin
                     state   <= ST_LOAD_STALL;
                     bub_cnt <= BUB_W'(LOAD_BUBBLES - 1);
                  end
               end else if (ctrl_flow) begin
                  state    <= ST_CTRL_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_LOAD_STALL: begin
               if (bub_cnt == BUB_W'(1)) begin
                  state <= ST_RUN;
               end else begin
                  bub_cnt <= bub_cnt - 1'b1;
               end
            end
            ST_CTRL_WAIT: begin
               // A resolve arriving on the last allowed wait cycle still wins
               // over the watchdog.
               if (resolve_valid) begin
                  if (resolve_taken) begin
                     pc_target <= resolve_target;
                     state     <= ST_REDIRECT;
                  end else begin
                     state <= ST_RUN;
                  end
               end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                  ctrl_timeout <= 1'b1;
                  state        <= ST_RUN;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_REDIRECT: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_write),
      .clear (1'b0),
      .count (stall_cycles)
   );

endmodule : pipeline_stall_controller

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Two controllers with different parameters share one stimulus stream:
//   u_a : LOAD_BUBBLES=1, MAX_WAIT=8, CNT_W=16
//   u_b : LOAD_BUBBLES=3, MAX_WAIT=5, CNT_W=4
// Each has its own behavioural model. Inputs change 2 time units after the
// rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

   localparam int AW = 32;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          lu    = 1'b0;
   logic          cf    = 1'b0;
   logic          rv    = 1'b0;
   logic          rt    = 1'b0;
   logic [AW-1:0] tgt   = '0;

   logic          a_pw, a_iw, a_fl, a_bb, a_sel, a_busy, a_tout;
   logic [AW-1:0] a_pct;
   logic [15:0]   a_stall;
   logic          b_pw, b_iw, b_fl, b_bb, b_sel, b_busy, b_tout;
   logic [AW-1:0] b_pct;
   logic [3:0]    b_stall;

   int n_vec  = 0;
   int n_err  = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   pipeline_stall_controller #(
      .ADDR_W(AW), .CNT_W(16), .LOAD_BUBBLES(1), .MAX_WAIT(8)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .ctrl_flow(cf),
      .resolve_valid(rv), .resolve_taken(rt), .resolve_target(tgt),
      .pc_write(a_pw), .ifid_write(a_iw), .ifid_flush(a_fl),
      .idex_bubble(a_bb), .pc_sel(a_sel), .pc_target(a_pct), .busy(a_busy),
      .ctrl_timeout(a_tout), .stall_cycles(a_stall)
   );

   pipeline_stall_controller #(
      .ADDR_W(AW), .CNT_W(4), .LOAD_BUBBLES(3), .MAX_WAIT(5)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .ctrl_flow(cf),
      .resolve_valid(rv), .resolve_taken(rt), .resolve_target(tgt),
      .pc_write(b_pw), .ifid_write(b_iw), .ifid_flush(b_fl),
      .idex_bubble(b_bb), .pc_sel(b_sel), .pc_target(b_pct), .busy(b_busy),
      .ctrl_timeout(b_tout), .stall_cycles(b_stall)
   );

   // ---------------------------------------------------------------- model
   typedef struct {
      int            bub_left;   // bubble cycles still owed after this one
      bit            waiting;    // a control transfer is outstanding
      int            waited;     // completed cycles spent waiting
      bit            redirect;   // next cycle loads the taken target
      logic [AW-1:0] tgt;
      bit            tout;
      int            stalls;
   } model_t;

   typedef struct packed {
      logic pw, iw, fl, bb, sel, busy;
   } ctl_t;

   function automatic model_t model_zero();
      model_t m;
      m.bub_left = 0; m.waiting = 1'b0; m.waited = 0; m.redirect = 1'b0;
      m.tgt = '0; m.tout = 1'b0; m.stalls = 0;
      return m;
   endfunction

   function automatic ctl_t expect_ctl(model_t m, logic rn, logic l, logic c);
      ctl_t e = '0;
      if (!rn) return e;
      if (m.bub_left > 0) begin
         e.bb = 1'b1; e.busy = 1'b1;
      end else if (m.waiting) begin
         e.fl = 1'b1; e.iw = 1'b1; e.busy = 1'b1;
      end else if (m.redirect) begin
         e.sel = 1'b1; e.pw = 1'b1; e.fl = 1'b1; e.busy = 1'b1;
      end else if (l) begin
         e.bb = 1'b1;
      end else if (c) begin
         e.fl = 1'b1; e.iw = 1'b1;
      end else begin
         e.pw = 1'b1; e.iw = 1'b1;
      end
      return e;
   endfunction

   function automatic model_t model_step(model_t m, int lb, int mw, int cw,
                                         logic l, logic c, logic v, logic t,
                                         logic [AW-1:0] g);
      model_t n = m;
      ctl_t   e = expect_ctl(m, 1'b1, l, c);
      if (!e.pw && (m.stalls < (1 << cw) - 1)) n.stalls = m.stalls + 1;
      if (m.bub_left > 0) begin
         n.bub_left = m.bub_left - 1;
      end else if (m.waiting) begin
         if (v) begin
            n.waiting = 1'b0;
            if (t) begin
               n.redirect = 1'b1;
               n.tgt      = g;
            end
         end else if (m.waited + 1 == mw) begin
            n.waiting = 1'b0;
            n.tout    = 1'b1;
         end else begin
            n.waited = m.waited + 1;
         end
      end else if (m.redirect) begin
         n.redirect = 1'b0;
      end else if (l) begin
         n.bub_left = lb - 1;
      end else if (c) begin
         n.waiting = 1'b1;
         n.waited  = 0;
      end
      return n;
   endfunction

   model_t ma, mb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= model_zero();
         mb <= model_zero();
      end else begin
         ma <= model_step(ma, 1, 8, 16, lu, cf, rv, rt, tgt);
         mb <= model_step(mb, 3, 5, 4, lu, cf, rv, rt, tgt);
      end
   end

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         ctl_t ea, eb;
         ea = expect_ctl(ma, rst_n, lu, cf);
         eb = expect_ctl(mb, rst_n, lu, cf);
         check("a.ctl",    {26'b0, a_pw, a_iw, a_fl, a_bb, a_sel, a_busy}, {26'b0, ea});
         check("a.target", a_pct, ma.tgt);
         check_bit("a.timeout", a_tout, ma.tout);
         check("a.stalls", {16'b0, a_stall}, 32'(ma.stalls));
         check("b.ctl",    {26'b0, b_pw, b_iw, b_fl, b_bb, b_sel, b_busy}, {26'b0, eb});
         check("b.target", b_pct, mb.tgt);
         check_bit("b.timeout", b_tout, mb.tout);
         check("b.stalls", {28'b0, b_stall}, 32'(mb.stalls));
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic drive(input logic l, input logic c, input logic v,
                        input logic t, input logic [AW-1:0] g);
      @(posedge clk);
      #2;
      lu = l; cf = c; rv = v; rt = t; tgt = g;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Idle after reset release
      idle(10);
      settle();
      check_bit("idle.pc_write", a_pw, 1'b1);
      check_bit("idle.ifid_write", a_iw, 1'b1);
      check_bit("idle.busy", a_busy, 1'b0);
      check("idle.a_stalls", {16'b0, a_stall}, 32'd0);
      check("idle.b_stalls", {28'b0, b_stall}, 32'd0);

      // Single load-use pulse: 1 bubble on u_a, 3 on u_b
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      settle();
      check_bit("lu.a_bubble", a_bb, 1'b1);
      check_bit("lu.a_pc_write", a_pw, 1'b0);
      idle(2);
      settle();
      check_bit("lu.b_bubble3", b_bb, 1'b1);
      check_bit("lu.a_released", a_bb, 1'b0);
      idle(1);
      settle();
      check("lu.a_stalls", {16'b0, a_stall}, 32'd1);
      check("lu.b_stalls", {28'b0, b_stall}, 32'd3);
      check_bit("lu.b_busy", b_busy, 1'b0);

      // Taken control transfer, resolved three cycles after ctrl_flow
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
      settle();
      check_bit("tk.flush", a_fl, 1'b1);
      check_bit("tk.pc_write", a_pw, 1'b0);
      idle(1);
      settle();
      check_bit("tk.pc_sel", a_sel, 1'b1);
      check_bit("tk.pc_write_redir", a_pw, 1'b1);
      check("tk.a_target", a_pct, 32'h40);
      check("tk.b_target", b_pct, 32'h40);
      check("tk.a_stalls", {16'b0, a_stall}, 32'd5);
      idle(1);
      settle();
      check_bit("tk.back_to_run", a_busy, 1'b0);
      check_bit("tk.pc_sel_off", a_sel, 1'b0);

      // Load hazard and ctrl_flow together, then ctrl_flow alone, not taken
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      settle();
      check_bit("lc.a_enter_wait", a_fl, 1'b1);
      check_bit("lc.a_no_bubble", a_bb, 1'b0);
      check_bit("lc.b_still_bubble", b_bb, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      settle();
      check_bit("lc.b_enter_wait", b_fl, 1'b1);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h99);
      idle(1);
      settle();
      check_bit("nt.a_busy", a_busy, 1'b0);
      check_bit("nt.a_pc_sel", a_sel, 1'b0);
      check_bit("nt.a_pc_write", a_pw, 1'b1);
      check("nt.b_target_kept", b_pct, 32'h40);

      // Watchdog: no resolve
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(8);
      settle();
      check_bit("to.a_last_wait", a_busy, 1'b1);
      check_bit("to.a_not_yet", a_tout, 1'b0);
      check_bit("to.b_timeout", b_tout, 1'b1);
      idle(1);
      settle();
      check_bit("to.a_timeout", a_tout, 1'b1);
      check_bit("to.a_run", a_busy, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h123);
      idle(1);
      settle();
      check_bit("to.late_resolve_ignored", a_sel, 1'b0);
      check("to.target_kept", a_pct, 32'h40);
      check_bit("to.sticky", a_tout, 1'b1);

      // Reset in the middle of a control wait
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(2);
      #1 rst_n = 1'b0;
      #1;
      check_bit("rst.flush", a_fl, 1'b0);
      check_bit("rst.ifid_write", a_iw, 1'b0);
      check_bit("rst.busy", a_busy, 1'b0);
      check("rst.target", a_pct, 32'h0);
      check_bit("rst.timeout", a_tout, 1'b0);
      check("rst.stalls", {16'b0, a_stall}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
      settle();
      check_bit("rst.no_redirect", a_sel, 1'b0);
      check_bit("rst.running", a_pw, 1'b1);
      idle(1);
      settle();
      check_bit("rst.no_redirect2", a_sel, 1'b0);
      check("rst.target_clear", a_pct, 32'h0);

      // Twenty stall cycles: u_b's 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(1);
      settle();
      check("sat.a_stalls", {16'b0, a_stall}, 32'd20);
      check("sat.b_stalls", {28'b0, b_stall}, 32'd15);

      // Resolve on the final allowed wait cycle beats the watchdog
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(7);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
      settle();
      check_bit("rw.a_waiting", a_busy, 1'b1);
      idle(1);
      settle();
      check_bit("rw.a_redirect", a_sel, 1'b1);
      check("rw.a_target", a_pct, 32'h80);
      check_bit("rw.a_no_timeout", a_tout, 1'b0);
      check_bit("rw.b_timeout", b_tout, 1'b1);
      check("rw.b_target", b_pct, 32'h0);

      // Randomised traffic with occasional asynchronous resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
               AW'($urandom));
      end
      idle(1);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipeline_stall_controller
